mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, bit-enable, 1-cycle-read-latency memory (cs/we/be/addr/din/dout) between NR requesters.
//  - Clears the memory after reset.
//  - Arbitrates valid/ready requests round-robin.
//  - Returns read data to the winning requester one cycle after acceptance.
//  - Sits between crypto-engine clients and each scratch RAM instance.
// PARAMETERS
//  NR     2   number of requesters (2..8)
//  DW     32  data width = memory bit-enable width
//  AW     6   address width
//  DEPTH  36  words cleared by the init sweep; must equal attached memory depth (AW**2 for the current model)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  init_done  out  1      high once the clear sweep completes
//  req_valid  in   NR     request present, per requester
//  req_ready  out  NR     request accepted this cycle (one-hot or zero)
//  req_we     in   NR     1 = write, 0 = read
//  req_be     in   NR*DW  bit enables, requester i at [i*DW +: DW]
//  req_addr   in   NR*AW  word address, requester i at [i*AW +: AW]
//  req_wdata  in   NR*DW  write data
//  rsp_valid  out  NR     one-hot: rsp_rdata is valid for requester i
//  rsp_rdata  out  DW     read data, shared by all requesters
//  mem_cs     out  1      memory chip-select
//  mem_we     out  1      memory write enable
//  mem_be     out  DW     memory bit enables
//  mem_addr   out  AW     memory address
//  mem_din    out  DW     memory write data
//  mem_dout   in   DW     memory read data; valid the cycle after a read is issued
// BEHAVIOUR
//  - Reset is synchronous and active-high on clk.
//    - While rst=1, all outputs are 0: init_done, req_ready, rsp_valid, mem_cs, mem_we, mem_be, mem_addr, mem_din.
//    - Reset value of rsp_rdata is don't-care.
//    - On the first edge with rst=1: state<=INIT, clr_ptr<=0, rr_ptr<=0, rsp_valid reg<=0.
//  - FSM states: INIT and RUN. The port is driven combinationally from the state/grant; the memory samples it at the next edge.
//  - INIT:
//    - mem_cs=1, mem_we=1, mem_be='1, mem_din=0, mem_addr=clr_ptr; req_ready=0.
//    - clr_ptr increments every cycle.
//    - After the write to DEPTH-1 is issued, go to RUN.
//    - The sweep takes exactly DEPTH cycles after rst deasserts.
//  - RUN:
//    - init_done=1.
//    - Winner = first requester with req_valid=1, searching from rr_ptr upward modulo NR.
//    - If there is a winner: req_ready[winner]=1 the same cycle; mem_* = the winner's fields; mem_cs=1.
//    - If there is no winner: mem_cs=0, mem_we=0, all other mem_* held at 0.
//    - After each grant: rr_ptr <= (winner+1) mod NR. With no grant, rr_ptr is unchanged.
//    - Throughput: one request per cycle, no bubbles.
//    - Starvation bound: a continuously valid requester is granted within NR cycles.
//  - Read response:
//    - A read accepted at edge N gives rsp_valid[winner]=1 in cycle N+1 (registered), with rsp_rdata=mem_dout.
//    - There is no response backpressure; the requester must sample it.
//    - Writes produce no response.
//  - Requests are ignored during INIT. valid may be held; it is not lost.
//  - Back-to-back reads from different requesters produce back-to-back one-hot rsp_valid in grant order.
//  - Reset mid-sweep or mid-read: the sweep restarts from 0 and pending rsp_valid is dropped.
//  - Address wrap: mem_addr is passed through unchanged; range checking is the requester's responsibility.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds two output ports.
//    - stat_grants  out  NR*32: per-requester grant count.
//    - stat_stall   out  32: count of cycles in RUN where more than one req_valid was high.
//    - All counters are saturating, cleared by rst, and not incremented in INIT.
//  MEM_ARB_STATS_EN undefined: neither port exists and no counter logic is generated.
// STRUCTURE
//  - Package mem_arb_pkg:
//    - state_e enum {INIT, RUN}
//    - STAT_W=32
//    - function next_rr(ptr, grant, nr)
//  - Sub-module rr_arbiter #(NR):
//    - Combinational one-hot grant from req and ptr, plus a registered pointer with en/rst.
//    - Instantiated once.
//  - Top-level contents: INIT sweep counter, port mux, response tag register, optional stats.
// TESTING
//  - Reset then idle, DEPTH=36:
//    - init_done rises exactly 36 cycles after rst falls.
//    - Every address reads back 0x0.
//  - Req0 writes addr 5, data 0xDEADBEEF, be 0xFFFF0000, then reads addr 5:
//    - rsp_valid=2'b01 one cycle after the read grant.
//    - rsp_rdata=0xDEAD0000.
//  - Both requesters continuously valid reads for 8 cycles:
//    - Grants alternate 0,1,0,1...
//    - rsp_valid alternates 01,10 one cycle later.
//  - rst asserted at sweep cycle 10, released:
//    - Sweep restarts at addr 0.
//    - init_done arrives 36 cycles after release.
//  - Req1 valid during INIT:
//    - req_ready stays 0 until RUN.
//    - Granted in the first RUN cycle.
//  - MEM_ARB_STATS_EN, 4 cycles of dual-valid requests:
//    - stat_stall=4.
//    - stat_grants = {2,2}.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types, widths and the round-robin pointer helper for
// mem_port_arbiter and its rr_arbiter sub-module.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int STAT_W = 32;
  localparam int MAX_NR = 8;
  localparam int PTR_W  = 3;

  // Pointer to the requester just after the granted one (mod nr);
  // with no grant the pointer is returned unchanged.
  function automatic logic [PTR_W-1:0] next_rr(input logic [PTR_W-1:0]  ptr,
                                               input logic [MAX_NR-1:0] grant,
                                               input int                nr);
    logic [PTR_W-1:0] nxt;
    nxt = ptr;
    for (int i = 0; i < MAX_NR; i++) begin
      if (grant[i] && (i < nr)) begin
        nxt = (i == nr - 1) ? {PTR_W{1'b0}} : PTR_W'(i + 1);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// rr_arbiter: combinational one-hot round-robin grant. The search starts at
// the registered pointer; the pointer moves past the winner after each grant.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NR = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [NR-1:0] req,
  output logic [NR-1:0] grant
);

  logic [PTR_W-1:0]  ptr;
  logic [MAX_NR-1:0] grant_ext;
  logic              found;
  int                idx;

  assign grant_ext = MAX_NR'(grant);

  // First requesting index at or after ptr, wrapping modulo NR.
  always_comb begin
    grant = {NR{1'b0}};
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < NR; off++) begin
      idx = (int'(ptr) + off) % NR;
      for (int i = 0; i < NR; i++) begin
        if (!found && (i == idx) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end else begin
          found = found;
        end
      end
    end
  end

  // Pointer advances only on a granted cycle while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= {PTR_W{1'b0}};
    end else if (en && (|grant)) begin
      ptr <= next_rr(ptr, grant_ext, NR);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, bit-enable, 1-cycle-read-latency
// memory between NR requesters. After reset it clears DEPTH words, then
// arbitrates round-robin and returns read data one cycle after acceptance.
// Optional MEM_ARB_STATS_EN adds stat_grants / stat_stall counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NR    = 2,
  parameter int DW    = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_done,
  input  logic [NR-1:0]    req_valid,
  output logic [NR-1:0]    req_ready,
  input  logic [NR-1:0]    req_we,
  input  logic [NR*DW-1:0] req_be,
  input  logic [NR*AW-1:0] req_addr,
  input  logic [NR*DW-1:0] req_wdata,
  output logic [NR-1:0]    rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [DW-1:0]    mem_be,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_din,
  input  logic [DW-1:0]    mem_dout
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NR*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]    stat_stall
`endif
);

  state_e        state;
  logic [AW-1:0] clr_ptr;
  logic          run;
  logic [NR-1:0] arb_req;
  logic [NR-1:0] grant;
  logic [NR-1:0] rsp_tag;

  assign run     = (state == RUN);
  // Requests are invisible to the arbiter during the clear sweep, so a held
  // valid simply waits for RUN.
  assign arb_req = run ? req_valid : {NR{1'b0}};

  rr_arbiter #(
    .NR (NR)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .req   (arb_req),
    .grant (grant)
  );

  // Sweep counter and INIT -> RUN transition once DEPTH-1 has been written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_ptr <= {AW{1'b0}};
    end else begin
      case (state)
        INIT: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(DEPTH - 1)) begin
            state <= RUN;
          end else begin
            state <= INIT;
          end
        end
        RUN: begin
          state   <= RUN;
          clr_ptr <= clr_ptr;
        end
        default: begin
          state   <= INIT;
          clr_ptr <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Memory port mux: clear writes in INIT, the winner's fields in RUN, all
  // zero while idle or in reset.
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = {DW{1'b0}};
    mem_addr  = {AW{1'b0}};
    mem_din   = {DW{1'b0}};
    req_ready = {NR{1'b0}};
    if (rst) begin
      mem_cs = 1'b0;
    end else if (!run) begin
      mem_cs   = 1'b1;
      mem_we   = 1'b1;
      mem_be   = {DW{1'b1}};
      mem_addr = clr_ptr;
      mem_din  = {DW{1'b0}};
    end else begin
      req_ready = grant;
      mem_cs    = |grant;
      for (int i = 0; i < NR; i++) begin
        if (grant[i]) begin
          mem_we   = req_we[i];
          mem_be   = req_be[i*DW +: DW];
          mem_addr = req_addr[i*AW +: AW];
          mem_din  = req_wdata[i*DW +: DW];
        end else begin
          mem_we = mem_we;
        end
      end
    end
  end

  // Response tag: remembers which requester's read was accepted this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_tag <= {NR{1'b0}};
    end else begin
      rsp_tag <= grant & ~req_we;
    end
  end

  assign rsp_valid = rst ? {NR{1'b0}} : rsp_tag;
  assign rsp_rdata = mem_dout;
  assign init_done = run & ~rst;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NR];
  logic [STAT_W-1:0] stall_cnt;

  // Saturating per-requester grant counters and contention counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        grant_cnt[i] <= {STAT_W{1'b0}};
      end
      stall_cnt <= {STAT_W{1'b0}};
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (grant[i] && (grant_cnt[i] != {STAT_W{1'b1}})) begin
          grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
        end else begin
          grant_cnt[i] <= grant_cnt[i];
        end
      end
      if (run && ($countones(req_valid) > 1) && (stall_cnt != {STAT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + STAT_W'(1);
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

  // Flatten grant counters onto the output bus.
  always_comb begin
    stat_grants = {(NR*STAT_W){1'b0}};
    for (int i = 0; i < NR; i++) begin
      stat_grants[i*STAT_W +: STAT_W] = grant_cnt[i];
    end
  end

  assign stat_stall = stall_cnt;
`endif

endmodule
